// File: rtl/rdma_pkt_arbiter.sv
// rdma_pkt_arbiter
//   Packet-level round-robin arbiter. It merges two AXI-Stream RDMA packet
//   sources onto one AXI-Stream output. A grant is held from the first beat of
//   a packet through its TLAST handshake, so packets are never interleaved.
//   The arbiter counts the packets it forwards from each input.
//
// Ports
//   clk, resetn            : clock; asynchronous active-low reset
//   AXIS_IN0_*             : packet source 0 (TDATA/TKEEP/TVALID/TLAST in, TREADY out)
//   AXIS_IN1_*             : packet source 1 (TDATA/TKEEP/TVALID/TLAST in, TREADY out)
//   AXIS_OUT_*             : merged stream (TDATA/TKEEP/TVALID/TLAST out, TREADY in)
//   pkt_count0/pkt_count1  : wrapping 32-bit count of packets forwarded per input
module rdma_pkt_arbiter #(
    parameter int DATA_WBITS = 512,
    parameter int DATA_WBYTS = DATA_WBITS / 8
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic [DATA_WBITS-1:0] AXIS_IN0_TDATA,
    input  logic [DATA_WBYTS-1:0] AXIS_IN0_TKEEP,
    input  logic                  AXIS_IN0_TVALID,
    input  logic                  AXIS_IN0_TLAST,
    output logic                  AXIS_IN0_TREADY,

    input  logic [DATA_WBITS-1:0] AXIS_IN1_TDATA,
    input  logic [DATA_WBYTS-1:0] AXIS_IN1_TKEEP,
    input  logic                  AXIS_IN1_TVALID,
    input  logic                  AXIS_IN1_TLAST,
    output logic                  AXIS_IN1_TREADY,

    output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
    output logic [DATA_WBYTS-1:0] AXIS_OUT_TKEEP,
    output logic                  AXIS_OUT_TVALID,
    output logic                  AXIS_OUT_TLAST,
    input  logic                  AXIS_OUT_TREADY,

    output logic [31:0]           pkt_count0,
    output logic [31:0]           pkt_count1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;     // most recently granted input
    logic   inc0, inc1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last       <= 1'b1;   // input 0 wins the first tie
            pkt_count0 <= '0;
            pkt_count1 <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (inc0) pkt_count0 <= pkt_count0 + 32'd1;
            if (inc1) pkt_count1 <= pkt_count1 + 32'd1;
        end
    end

    // Outputs depend only on the registered state and the granted input's
    // signals. TREADY therefore never feeds back into any TVALID.
    always_comb begin
        state_nxt       = state;
        last_nxt        = last;
        inc0            = 1'b0;
        inc1            = 1'b0;
        AXIS_OUT_TDATA  = AXIS_IN0_TDATA;
        AXIS_OUT_TKEEP  = AXIS_IN0_TKEEP;
        AXIS_OUT_TLAST  = AXIS_IN0_TLAST;
        AXIS_OUT_TVALID = 1'b0;
        AXIS_IN0_TREADY = 1'b0;
        AXIS_IN1_TREADY = 1'b0;

        case (state)
            IDLE: begin
                if (AXIS_IN0_TVALID && !AXIS_IN1_TVALID)
                    state_nxt = GRANT0;
                else if (AXIS_IN1_TVALID && !AXIS_IN0_TVALID)
                    state_nxt = GRANT1;
                else if (AXIS_IN0_TVALID && AXIS_IN1_TVALID)
                    state_nxt = last ? GRANT0 : GRANT1;
            end
            GRANT0: begin
                AXIS_OUT_TVALID = AXIS_IN0_TVALID;
                AXIS_IN0_TREADY = AXIS_OUT_TREADY;
                if (AXIS_IN0_TVALID && AXIS_OUT_TREADY && AXIS_IN0_TLAST) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                    inc0      = 1'b1;
                end
            end
            GRANT1: begin
                AXIS_OUT_TDATA  = AXIS_IN1_TDATA;
                AXIS_OUT_TKEEP  = AXIS_IN1_TKEEP;
                AXIS_OUT_TLAST  = AXIS_IN1_TLAST;
                AXIS_OUT_TVALID = AXIS_IN1_TVALID;
                AXIS_IN1_TREADY = AXIS_OUT_TREADY;
                if (AXIS_IN1_TVALID && AXIS_OUT_TREADY && AXIS_IN1_TLAST) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                    inc1      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/rdma_pkt_arbiter.md
# rdma_pkt_arbiter

Packet-level round-robin arbiter that merges two AXI-Stream RDMA packet sources onto one AXI-Stream output. It sits downstream of the per-port RDMA packet filters and ahead of the RDMA write engine, so two Ethernet ports can share a single RDMA datapath. A grant is held from the first beat of a packet through its TLAST handshake, so packets are never interleaved. Forwarded packets are counted per input.

## Interface
- DATA_WBITS, 512, width of TDATA in bits
- DATA_WBYTS, DATA_WBITS/8, width of TKEEP
- clk  input  1  single clock for all logic
- resetn  input  1  reset, asynchronous assert, active-low
- AXIS_IN0_TDATA / TKEEP / TVALID / TLAST  input  DATA_WBITS / DATA_WBYTS / 1 / 1  packet source 0
- AXIS_IN0_TREADY  output  1  ready to source 0
- AXIS_IN1_TDATA / TKEEP / TVALID / TLAST  input  DATA_WBITS / DATA_WBYTS / 1 / 1  packet source 1
- AXIS_IN1_TREADY  output  1  ready to source 1
- AXIS_OUT_TDATA / TKEEP / TVALID / TLAST  output  DATA_WBITS / DATA_WBYTS / 1 / 1  merged packet stream
- AXIS_OUT_TREADY  input  1  ready from downstream
- pkt_count0  output  32  packets forwarded from source 0
- pkt_count1  output  32  packets forwarded from source 1

## Operation
- State machine, registered: IDLE, GRANT0, GRANT1. Also a registered `last` bit, which records the most recently granted input.
- IDLE:
  - AXIS_OUT_TVALID = 0, both IN TREADY = 0.
  - Only IN0 TVALID -> GRANT0. Only IN1 TVALID -> GRANT1.
  - Both valid -> grant the input != `last`.
  - Neither valid -> stay in IDLE.
- GRANTn datapath is combinational, zero added latency:
  - AXIS_OUT_TDATA/TKEEP/TLAST/TVALID = INn signals.
  - INn TREADY = AXIS_OUT_TREADY; the other input's TREADY = 0.
- GRANTn exit: on an INn TVALID & TREADY & TLAST handshake:
  - go to IDLE, set `last` = n, pkt_countn += 1.
  - TVALID deasserting mid-packet does not release the grant.
- When not granted, output TDATA/TKEEP/TLAST are don't-care; drive them from IN0.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0. They count only in the TLAST handshake cycle.
- The non-granted input is never acknowledged. Its TVALID/TDATA may be held indefinitely, as AXI requires.

## Timing
- Reset (resetn low, asynchronous) forces:
  - state = IDLE, `last` = 1 (input 0 wins the first tie), pkt_count0 = pkt_count1 = 0.
  - AXIS_OUT_TVALID = 0, both IN TREADY = 0.
- These values take effect immediately on assertion. Logic leaves reset on the first clk edge after resetn deasserts.
- Reset mid-packet: the packet is abandoned, with no partial TLAST generated. The upstream and downstream blocks are reset together.
- Arbitration latency:
  - An input TVALID seen in IDLE at edge k gives GRANT state after edge k.
  - The output TVALID is visible in the cycle following edge k.
- Exactly one idle cycle between consecutive packets, whichever source sends them.
- Single-beat packet (TLAST on first beat): GRANTn -> IDLE on the same handshake edge.
- Backpressure: AXIS_OUT_TREADY low stalls the granted input combinationally. There is no internal buffering.
- Simultaneous arrival with continuous traffic on both inputs gives strict alternation 0,1,0,1...
- The arbiter must not create a combinational path from AXIS_OUT_TREADY to any TVALID.

## Test plan
- Single source: IN0 sends a 4-beat packet, IN1 idle, TREADY=1.
  - Required: output shows 4 beats starting the cycle after IN0 TVALID rises, TLAST on beat 4.
  - Required: pkt_count0 = 1, pkt_count1 = 0, IN1_TREADY held 0 throughout.
- Tie after reset: IN0 and IN1 both present 3-beat packets in the same cycle.
  - Required: IN0's packet is output first, then one idle cycle, then IN1's packet.
  - Required: both counters = 1.
- Fairness: both inputs stream 10 packets each of 2 beats back-to-back.
  - Required: output alternates sources 0,1,... with no interleaving within a packet.
  - Required: final counts 10/10.
- Backpressure and mid-packet gaps: toggle AXIS_OUT_TREADY pseudo-randomly and drop IN1 TVALID for 3 cycles mid-packet.
  - Required: grant stays on IN1 and data is unchanged while stalled.
  - Required: IN0 is not acknowledged until IN1's TLAST handshake.
- Single-beat packets: IN1 sends 5 one-beat packets, IN0 idle.
  - Required: 5 output beats, each with TLAST=1, separated by one idle cycle each.
  - Required: pkt_count1 = 5.
- Reset mid-packet: assert resetn low during beat 2 of a 4-beat IN0 packet.
  - Required: AXIS_OUT_TVALID and both TREADYs go 0 without waiting for a clk edge, and counters read 0.
  - Required: after release, a new IN1 packet is granted normally.
